// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with programmable brightness.
// Each digit value is latched into a shadow register at strobe start, so bus writes never tear a lit digit.
module seg_scan_ctrl #(
  parameter int DIGITS       = 3,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        addr,
  input  logic [7:0]        wr_data,
  output logic [7:0]        rd_data,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] digit_sel,
  output logic              frame_tick
);

  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_N    = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] EIGHTH     = CNT_W'(DWELL_CYCLES / 8);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [3:0]       CTRL_ADDR   = 4'd8;
  localparam logic [3:0]       STATUS_ADDR = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } state_t;

  logic [7:0]        digit_q [DIGITS];
  logic              en_q;
  logic [2:0]        bright_ctrl_q;

  state_t            state_q, state_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [2:0]        bright_q, bright_nxt;
  logic [7:0]        shadow_q, shadow_nxt;
  logic              tick_nxt;
  logic              slot_end;

  logic              ctrl_wr;
  logic              en_eff;
  logic [2:0]        bright_eff;
  logic [CNT_W-1:0]  on_len;
  logic [CNT_W-1:0]  off_len;
  logic [7:0]        rd_nxt;
  logic [DIGITS-1:0] sel_nxt;
  logic [7:0]        seg_nxt;

  function automatic logic [7:0] seg_decode(input logic [7:0] d);
    logic [7:0] s;
    case (d[3:0])
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    if (d[7]) s[7] = 1'b0;
    if (d[6]) s = 8'hFF;
    return s;
  endfunction

  // A CTRL write in the same cycle is seen immediately by the scan FSM.
  assign ctrl_wr    = wr_en && (addr == CTRL_ADDR);
  assign en_eff     = ctrl_wr ? wr_data[0]   : en_q;
  assign bright_eff = ctrl_wr ? wr_data[3:1] : bright_ctrl_q;

  assign on_len  = (CNT_W'(bright_q) + CNT_ONE) * EIGHTH;
  assign off_len = DWELL_N - on_len;

  always_comb begin
    state_nxt  = state_q;
    idx_nxt    = idx_q;
    cnt_nxt    = cnt_q + CNT_ONE;
    bright_nxt = bright_q;
    shadow_nxt = shadow_q;
    tick_nxt   = 1'b0;
    slot_end   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (en_eff) begin
          state_nxt  = BLANK;
          bright_nxt = bright_eff;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_nxt  = ON;
          cnt_nxt    = '0;
          shadow_nxt = digit_q[idx_q];
        end
      end
      ON: begin
        if (cnt_q == on_len - CNT_ONE) begin
          if (on_len < DWELL_N) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end else begin
            slot_end = 1'b1;
          end
        end
      end
      OFF: begin
        if (cnt_q == off_len - CNT_ONE) slot_end = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (slot_end) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
      if (idx_q == LAST_IDX) begin
        idx_nxt    = '0;
        tick_nxt   = 1'b1;
        bright_nxt = bright_eff;
      end else begin
        idx_nxt = idx_q + IDX_ONE;
      end
    end

    // Dropping enable aborts the frame on the next clock, without a frame tick.
    if ((state_q != IDLE) && !en_eff) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      tick_nxt  = 1'b0;
    end
  end

  always_comb begin
    rd_nxt = 8'h00;
    for (int i = 0; i < DIGITS; i++) begin
      if (addr == 4'(i)) rd_nxt = digit_q[i];
    end
    if (addr == CTRL_ADDR)   rd_nxt = {4'b0000, bright_ctrl_q, en_q};
    if (addr == STATUS_ADDR) rd_nxt = {2'b00, state_q, 1'b0, 3'(idx_q)};
  end

  assign sel_nxt = (state_nxt == ON) ? (DIGITS'(1) << idx_nxt) : '0;
  assign seg_nxt = (state_nxt == ON) ? seg_decode(shadow_nxt) : 8'hFF;

  // Register stage: FSM state, bus registers and display outputs update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      bright_q      <= 3'd7;
      en_q          <= 1'b0;
      bright_ctrl_q <= 3'd7;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= 8'h00;
      seg_out       <= 8'hFF;
      digit_sel     <= '0;
      frame_tick    <= 1'b0;
      rd_data       <= 8'h00;
    end else begin
      state_q    <= state_nxt;
      idx_q      <= idx_nxt;
      cnt_q      <= cnt_nxt;
      bright_q   <= bright_nxt;
      seg_out    <= seg_nxt;
      digit_sel  <= sel_nxt;
      frame_tick <= tick_nxt;
      rd_data    <= rd_nxt;
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && (addr == 4'(i))) digit_q[i] <= wr_data;
      end
      if (ctrl_wr) begin
        en_q          <= wr_data[0];
        bright_ctrl_q <= wr_data[3:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_nxt;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random bus traffic, checked every clock
// against a frame-position model (time since scan start, divided into slots).
module tb_seg_scan_ctrl;
  localparam int ND    = 3;
  localparam int DW    = 16;
  localparam int BL    = 2;
  localparam int SLOT  = BL + DW;
  localparam int FRAME = ND * SLOT;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [3:0]    addr;
  logic [7:0]    wr_data;
  logic [7:0]    rd_data;
  logic [7:0]    seg_out;
  logic [ND-1:0] digit_sel;
  logic          frame_tick;

  seg_scan_ctrl #(.DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .seg_out(seg_out), .digit_sel(digit_sel), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_dig [ND];
  bit         m_en;
  logic [2:0] m_br;
  bit         m_run;
  int         m_t;
  logic [2:0] m_bq;
  logic [7:0] m_sh;
  bit         m_tick;
  logic [7:0] m_rd;

  // Statistics taken from observed outputs
  int cyc = 0;
  int tick_cnt = 0;
  int lit_cnt = 0;
  int last_tick = -1;
  int lit_at_tick = 0;
  int gap = 0;
  int frame_lit = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int on_len(input logic [2:0] b);
    return (int'(b) + 1) * DW / 8;
  endfunction

  function automatic logic [7:0] ref_seg(input logic [7:0] d);
    logic [7:0] s;
    if (d[6]) return 8'hFF;
    s = HEX_SEG[d[3:0]];
    if (d[7]) s[7] = 1'b0;
    return s;
  endfunction

  function automatic bit m_lit();
    int pos;
    pos = m_t % SLOT;
    return m_run && (pos >= BL) && (pos - BL < on_len(m_bq));
  endfunction

  task automatic model_edge();
    logic [7:0] old_dig [ND];
    int slot, pos, st;
    bit ctrl_wr, en_eff;
    logic [2:0] br_eff;
    if (reset) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
      m_en = 1'b0; m_br = 3'd7; m_bq = 3'd7;
      m_run = 1'b0; m_t = 0; m_tick = 1'b0; m_rd = 8'h00;
      return;
    end
    slot = m_run ? m_t / SLOT : 0;
    pos  = m_t % SLOT;
    if (!m_run) st = 0;
    else if (pos < BL) st = 1;
    else if (pos - BL < on_len(m_bq)) st = 2;
    else st = 3;
    if (int'(addr) < ND) m_rd = m_dig[int'(addr)];
    else if (addr == 4'd8) m_rd = {4'h0, m_br, m_en};
    else if (addr == 4'd9) m_rd = {2'b00, 2'(st), 1'b0, 3'(slot)};
    else m_rd = 8'h00;

    ctrl_wr = wr_en && (addr == 4'd8);
    en_eff  = ctrl_wr ? wr_data[0] : m_en;
    br_eff  = ctrl_wr ? wr_data[3:1] : m_br;
    old_dig = m_dig;
    m_tick  = 1'b0;
    if (!m_run) begin
      if (en_eff) begin
        m_run = 1'b1; m_t = 0; m_bq = br_eff;
      end
    end else if (!en_eff) begin
      m_run = 1'b0; m_t = 0;
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t = 0; m_tick = 1'b1; m_bq = br_eff;
      end
    end
    if (m_run && (m_t % SLOT == BL)) m_sh = old_dig[m_t / SLOT];
    if (wr_en && int'(addr) < ND) m_dig[int'(addr)] = wr_data;
    if (ctrl_wr) begin
      m_en = wr_data[0]; m_br = wr_data[3:1];
    end
  endtask

  task automatic step();
    logic [7:0]    e_seg;
    logic [ND-1:0] e_sel;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    e_sel = m_lit() ? ND'(1 << (m_t / SLOT)) : '0;
    e_seg = m_lit() ? ref_seg(m_sh) : 8'hFF;
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("rd_data", 32'(rd_data), 32'(m_rd));
    if (digit_sel != '0) lit_cnt++;
    if (frame_tick) begin
      tick_cnt++;
      if (last_tick >= 0) begin
        gap = cyc - last_tick;
        frame_lit = lit_cnt - lit_at_tick;
      end
      last_tick = cyc;
      lit_at_tick = lit_cnt;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clear_stats();
    tick_cnt = 0; last_tick = -1; gap = 0; frame_lit = -1;
  endtask

  task automatic wait_sel(input logic [ND-1:0] tgt);
    for (int k = 0; k < 200 && digit_sel !== tgt; k++) step();
    check("wait_sel", 32'(digit_sel), 32'(tgt));
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 200 && frame_tick !== 1'b1; k++) step();
    check("wait_tick", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; addr = 4'd8; wr_data = 8'h00;
    run(2);
    reset = 1'b0;

    // Idle after reset
    clear_stats();
    run(20);
    check("idle_no_tick", 32'(tick_cnt), 32'd0);
    check("ctrl_reset_rd", 32'(rd_data), 32'h0E);

    // Full brightness scan
    write_reg(4'd0, 8'h05);
    write_reg(4'd1, 8'h09);
    write_reg(4'd2, 8'h8A);
    clear_stats();
    write_reg(4'd8, 8'h0F);
    run(3 * FRAME);
    check("period_b7", 32'(gap), 32'd54);
    check("lit_b7", 32'(frame_lit), 32'd48);

    // Brightness 3 then 0
    write_reg(4'd8, 8'h07);
    clear_stats();
    run(3 * FRAME);
    check("period_b3", 32'(gap), 32'd54);
    check("lit_b3", 32'(frame_lit), 32'd24);
    write_reg(4'd8, 8'h01);
    clear_stats();
    run(3 * FRAME);
    check("period_b0", 32'(gap), 32'd54);
    check("lit_b0", 32'(frame_lit), 32'd6);

    // Blanked digit 1 still strobes, with all segments off
    wait_tick();
    write_reg(4'd1, 8'h43);
    wait_sel(3'b010);
    check("blank_seg", 32'(seg_out), 32'hFF);

    // Digit 0 rewritten while lit holds its old pattern until its next strobe
    write_reg(4'd8, 8'h0F);
    wait_tick();
    wait_sel(3'b001);
    run(3);
    write_reg(4'd0, 8'h03);
    check("d0_hold", 32'(seg_out), 32'h92);
    wait_sel(3'b010);
    wait_sel(3'b001);
    check("d0_new", 32'(seg_out), 32'hB0);

    // Enable dropped at the 5th lit clock of digit 1
    wait_sel(3'b010);
    run(4);
    write_reg(4'd8, 8'h0E);
    check("dis_sel", 32'(digit_sel), 32'd0);
    check("dis_seg", 32'(seg_out), 32'hFF);
    addr = 4'd9;
    step();
    check("dis_status", 32'(rd_data), 32'h00);

    // Re-enable restarts at digit 0 after the blanking interval
    write_reg(4'd8, 8'h0F);
    step();
    check("restart_blank", 32'(digit_sel), 32'd0);
    step();
    check("restart_sel", 32'(digit_sel), 32'b001);

    // Random bus traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] d;
      r = int'($urandom_range(0, 15));
      d = 8'($urandom);
      if (r == 0) begin
        d[0] = ($urandom_range(0, 7) != 0);
        wr_en = 1'b1; addr = 4'd8; wr_data = d;
      end else if (r == 1) begin
        wr_en = 1'b1; addr = 4'($urandom_range(0, ND - 1)); wr_data = d;
      end else if (r == 2) begin
        wr_en = 1'b1; wr_data = d;
        addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(3, 7)) : 4'($urandom_range(9, 15));
      end else begin
        wr_en = 1'b0; addr = 4'($urandom_range(0, 15));
      end
      step();
    end
    wr_en = 1'b0;

    // Reset mid-strobe wins over a simultaneous CTRL write
    write_reg(4'd8, 8'h0F);
    wait_sel(3'b010);
    run(3);
    reset = 1'b1; wr_en = 1'b1; addr = 4'd8; wr_data = 8'h05;
    step();
    check("rst_sel", 32'(digit_sel), 32'd0);
    check("rst_seg", 32'(seg_out), 32'hFF);
    reset = 1'b0; wr_en = 1'b0;
    step();
    check("rst_ctrl_rd", 32'(rd_data), 32'h0E);
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
